// File: rtl/exe_pkg.sv
// exe_pkg: command and branch encodings plus the MDU state type shared by the execute stage.
// ALU codes 0-10 are the native ALU set; 11-15 belong to the multiply/divide unit.
package exe_pkg;
    localparam logic [3:0] CMD_ADD  = 4'd0;
    localparam logic [3:0] CMD_SUB  = 4'd1;
    localparam logic [3:0] CMD_AND  = 4'd2;
    localparam logic [3:0] CMD_OR   = 4'd3;
    localparam logic [3:0] CMD_NOR  = 4'd4;
    localparam logic [3:0] CMD_XOR  = 4'd5;
    localparam logic [3:0] CMD_SLL  = 4'd6;
    localparam logic [3:0] CMD_SRL  = 4'd7;
    localparam logic [3:0] CMD_SRA  = 4'd8;
    localparam logic [3:0] CMD_SLT  = 4'd9;
    localparam logic [3:0] CMD_SLTU = 4'd10;
    localparam logic [3:0] CMD_MULU = 4'd11;
    localparam logic [3:0] CMD_DIVU = 4'd12;
    localparam logic [3:0] CMD_MFHI = 4'd13;
    localparam logic [3:0] CMD_MFLO = 4'd14;

    localparam logic [1:0] BR_NONE = 2'd0;
    localparam logic [1:0] BR_BEZ  = 2'd1;
    localparam logic [1:0] BR_BNE  = 2'd2;
    localparam logic [1:0] BR_JMP  = 2'd3;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} mdu_state_e;
endpackage

// File: rtl/exe_stage_mdu_mdu.sv
// mdu_iter: iterative unsigned multiply (shift-add) / divide (restoring), one bit per cycle.
// op = 1 selects divide; HI/LO are written on the last iteration edge.
module mdu_iter
    import exe_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             op,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);

    mdu_state_e         r_state;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_op;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_shl;
    logic [WIDTH:0]     w_diff;
    logic [2*WIDTH-1:0] w_next;

    // Multiply: acc = {partial, multiplier}; divide: acc = {remainder, dividend bits left}.
    assign w_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_b} : '0);
    assign w_shl  = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_diff = w_shl - {1'b0, r_b};
    assign w_next = !r_op       ? {w_sum, r_acc[WIDTH-1:1]} :
                    w_diff[WIDTH] ? {w_shl[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0} :
                                    {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_b     <= '0;
            r_op    <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            case (r_state)
                IDLE: if (start) begin
                    r_state <= BUSY;
                    r_cnt   <= CW'(WIDTH - 1);
                    r_acc   <= {{WIDTH{1'b0}}, a};
                    r_b     <= b;
                    r_op    <= op;
                end
                BUSY: begin
                    r_acc <= w_next;
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == '0) begin
                        r_state      <= DONE;
                        {r_hi, r_lo} <= w_next;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy = r_state == BUSY;
    assign done = r_state == DONE;
    assign hi   = r_hi;
    assign lo   = r_lo;
endmodule

// File: rtl/exe_stage_mdu.sv
// exe_stage_mdu: MIPS execute stage with forwarding, ALU, branch resolution and an iterative MDU.
// A MULU/DIVU stalls upstream for WIDTH+1 cycles and retires with LO in the DONE cycle.
module exe_stage_mdu
    import exe_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int FWD_SRCS = 2,
    parameter int SEL_W    = $clog2(FWD_SRCS + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic [3:0]                exe_cmd,
    input  logic [WIDTH-1:0]          val1,
    input  logic [WIDTH-1:0]          val2,
    input  logic [WIDTH-1:0]          reg_2,
    input  logic [WIDTH-1:0]          pc,
    input  logic [1:0]                br_type,
    input  logic [SEL_W-1:0]          sel_a,
    input  logic [SEL_W-1:0]          sel_b,
    input  logic [SEL_W-1:0]          sel_st,
    input  logic [FWD_SRCS*WIDTH-1:0] fwd_data,
    output logic [WIDTH-1:0]          alu_result,
    output logic [WIDTH-1:0]          src2_val,
    output logic [WIDTH-1:0]          br_addr,
    output logic                      br_taken,
    output logic                      stall,
    output logic                      out_valid
);
    localparam int SH = $clog2(WIDTH);

    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH-1:0] w_hi;
    logic [WIDTH-1:0] w_lo;
    logic [SH-1:0]    w_sh;
    logic             w_start;
    logic             w_busy;
    logic             w_done;

    // Out-of-range selects fall back to the local operand.
    function automatic logic [WIDTH-1:0] fwd_sel(input logic [SEL_W-1:0] s, input logic [WIDTH-1:0] loc,
                                                 input logic [FWD_SRCS*WIDTH-1:0] srcs);
        fwd_sel = loc;
        for (int k = 1; k <= FWD_SRCS; k++)
            if (s == SEL_W'(k)) fwd_sel = srcs[k*WIDTH-1 -: WIDTH];
    endfunction

    assign w_a      = fwd_sel(sel_a, val1, fwd_data);
    assign w_b      = fwd_sel(sel_b, val2, fwd_data);
    assign src2_val = fwd_sel(sel_st, reg_2, fwd_data);
    assign w_sh     = w_b[SH-1:0];

    assign w_start   = rst && in_valid && (exe_cmd == CMD_MULU || exe_cmd == CMD_DIVU);
    assign stall     = w_busy || (w_start && !w_done);
    assign out_valid = in_valid && !stall;

    mdu_iter #(.WIDTH(WIDTH)) u_mdu (
        .clk  (clk),
        .rst  (rst),
        .start(w_start),
        .a    (w_a),
        .b    (w_b),
        .op   (exe_cmd == CMD_DIVU),
        .busy (w_busy),
        .done (w_done),
        .hi   (w_hi),
        .lo   (w_lo)
    );

    always_comb begin
        case (exe_cmd)
            CMD_ADD:  alu_result = w_a + w_b;
            CMD_SUB:  alu_result = w_a - w_b;
            CMD_AND:  alu_result = w_a & w_b;
            CMD_OR:   alu_result = w_a | w_b;
            CMD_NOR:  alu_result = ~(w_a | w_b);
            CMD_XOR:  alu_result = w_a ^ w_b;
            CMD_SLL:  alu_result = w_a << w_sh;
            CMD_SRL:  alu_result = w_a >> w_sh;
            CMD_SRA:  alu_result = $signed(w_a) >>> w_sh;
            CMD_SLT:  alu_result = {{(WIDTH-1){1'b0}}, $signed(w_a) < $signed(w_b)};
            CMD_SLTU: alu_result = {{(WIDTH-1){1'b0}}, w_a < w_b};
            CMD_MULU, CMD_DIVU, CMD_MFLO: alu_result = w_lo;
            CMD_MFHI: alu_result = w_hi;
            default:  alu_result = '0;
        endcase
    end

    assign br_addr  = pc + (val2 << 2);
    assign br_taken = in_valid && (br_type == BR_JMP || (br_type == BR_BEZ && w_a == '0) ||
                                   (br_type == BR_BNE && w_a != src2_val));
endmodule

// File: tb/tb_exe_stage_mdu.sv
// tb_exe_stage_mdu: directed and randomized checks of exe_stage_mdu against a behavioural model.
module tb_exe_stage_mdu;
    localparam int W  = 32;
    localparam int NF = 3;
    localparam int SW = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic [3:0]      exe_cmd;
    logic [W-1:0]    val1, val2, reg_2, pc;
    logic [1:0]      br_type;
    logic [SW-1:0]   sel_a, sel_b, sel_st;
    logic [W-1:0]    src [1:NF];
    logic [NF*W-1:0] fwd_data;
    logic [W-1:0]    alu_result, src2_val, br_addr;
    logic            br_taken, stall, out_valid;
    logic [W-1:0]    m_hi = '0;
    logic [W-1:0]    m_lo = '0;
    int              n_cmp = 0;
    int              n_err = 0;

    assign fwd_data = {src[3], src[2], src[1]};
    always #5 clk = ~clk;

    exe_stage_mdu #(.WIDTH(W), .FWD_SRCS(NF), .SEL_W(SW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .exe_cmd(exe_cmd),
        .val1(val1), .val2(val2), .reg_2(reg_2), .pc(pc), .br_type(br_type),
        .sel_a(sel_a), .sel_b(sel_b), .sel_st(sel_st), .fwd_data(fwd_data),
        .alu_result(alu_result), .src2_val(src2_val), .br_addr(br_addr),
        .br_taken(br_taken), .stall(stall), .out_valid(out_valid)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] m_fwd(input logic [SW-1:0] s, input logic [W-1:0] loc);
        if (s >= 1 && s <= NF) return src[s];
        return loc;
    endfunction

    function automatic logic [W-1:0] m_alu(input logic [3:0] cmd, input logic [W-1:0] a, input logic [W-1:0] b);
        int sa, sb, n;
        sa = a;
        sb = b;
        n  = int'(b % 32);
        case (cmd)
            0:  return a + b;
            1:  return a - b;
            2:  return a & b;
            3:  return a | b;
            4:  return ~(a | b);
            5:  return a ^ b;
            6:  return a * (33'd1 << n);
            7:  return a / (33'd1 << n);
            8:  return sa >>> n;
            9:  return (sa < sb) ? 1 : 0;
            10: return (a < b) ? 1 : 0;
            13: return m_hi;
            14: return m_lo;
            default: return 0;
        endcase
    endfunction

    task automatic comb_check(input string tag);
        logic [W-1:0] a, b, st;
        logic         tk;
        a  = m_fwd(sel_a, val1);
        b  = m_fwd(sel_b, val2);
        st = m_fwd(sel_st, reg_2);
        tk = in_valid && (br_type == 3 || (br_type == 1 && a == 0) || (br_type == 2 && a != st));
        check({tag, "_alu"}, alu_result, m_alu(exe_cmd, a, b));
        check({tag, "_st"}, src2_val, st);
        check({tag, "_badr"}, br_addr, W'(pc + val2 * 4));
        check({tag, "_btk"}, br_taken, tk);
        check({tag, "_stall"}, stall, 0);
        check({tag, "_ov"}, out_valid, in_valid);
    endtask

    task automatic mdu_run(input logic [3:0] cmd, input logic [W-1:0] a, input logic [W-1:0] b, input bit via_fwd);
        logic [2*W-1:0] p;
        int             n;
        n = 0;
        @(negedge clk);
        in_valid = 1; exe_cmd = cmd; br_type = 0; sel_b = 0; sel_st = 0; val2 = b;
        if (via_fwd) begin sel_a = 2; src[2] = a; val1 = ~a; end
        else begin sel_a = 0; val1 = a; end
        #1;
        check("mdu_start_stall", stall, 1);
        check("mdu_start_ov", out_valid, 0);
        if (cmd == 11) begin
            p = 64'(a) * 64'(b);
            m_hi = p[2*W-1:W];
            m_lo = p[W-1:0];
        end else if (b == 0) begin
            m_lo = '1;
            m_hi = a;
        end else begin
            m_lo = a / b;
            m_hi = a % b;
        end
        while (stall && n < W + 8) begin
            @(negedge clk);
            n++;
            val1 = $urandom; val2 = $urandom;
            for (int k = 1; k <= NF; k++) src[k] = $urandom;
            #1;
        end
        check("mdu_stall_cycles", n, W + 1);
        check("mdu_done_ov", out_valid, 1);
        check("mdu_done_lo", alu_result, m_lo);
        @(negedge clk);
        exe_cmd = 13;
        #1;
        check("mfhi", alu_result, m_hi);
        check("mfhi_stall", stall, 0);
        @(negedge clk);
        exe_cmd = 14;
        #1;
        check("mflo", alu_result, m_lo);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [3:0] c;
        rst = 0; in_valid = 1; exe_cmd = 11; val1 = 5; val2 = 6; reg_2 = 0; pc = 0;
        br_type = 0; sel_a = 0; sel_b = 0; sel_st = 0;
        for (int k = 1; k <= NF; k++) src[k] = '0;
        #1;
        check("rst_stall", stall, 0);
        check("rst_ov", out_valid, 1);
        exe_cmd = 13;
        #1;
        check("rst_hi", alu_result, 0);
        repeat (2) @(negedge clk);
        rst = 1;

        mdu_run(11, 7, 6, 0);
        mdu_run(11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        mdu_run(12, 100, 7, 0);
        mdu_run(12, 5, 0, 0);
        mdu_run(11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);

        // Reset in the middle of a multiply.
        @(negedge clk);
        in_valid = 1; exe_cmd = 11; sel_a = 0; sel_b = 0; val1 = 123; val2 = 456;
        repeat (10) @(negedge clk);
        #1;
        check("busy_pre_rst", stall, 1);
        rst = 0;
        #1;
        check("midrst_stall", stall, 0);
        check("midrst_ov", out_valid, 1);
        m_hi = '0;
        m_lo = '0;
        exe_cmd = 13;
        #1;
        check("midrst_hi", alu_result, 0);
        exe_cmd = 14;
        #1;
        check("midrst_lo", alu_result, 0);
        @(negedge clk);
        rst = 1;
        mdu_run(11, 3, 3, 0);

        // Directed forwarding and branch cases.
        @(negedge clk);
        in_valid = 1; exe_cmd = 0; br_type = 0; src[3] = 32'h10; sel_a = 3; sel_b = 0; val1 = 32'h99; val2 = 1;
        #1;
        check("fwd_src3", alu_result, 32'h11);
        sel_a = 5; val1 = 32'h20;
        #1;
        check("fwd_fallback", alu_result, 32'h21);
        sel_a = 0; sel_b = 1; src[1] = 7;
        #1;
        check("fwd_b_src1", alu_result, 32'h27);
        br_type = 2; sel_a = 1; src[1] = 4; sel_st = 0; reg_2 = 4; pc = 32'h100; val2 = 3; sel_b = 0;
        #1;
        check("bne_equal", br_taken, 0);
        check("br_addr", br_addr, 32'h10C);
        reg_2 = 5;
        #1;
        check("bne_differ", br_taken, 1);
        br_type = 3; in_valid = 0;
        #1;
        check("jmp_invalid", br_taken, 0);
        br_type = 1; in_valid = 1; sel_a = 0; val1 = 0;
        #1;
        check("bez_zero", br_taken, 1);

        // Randomized combinational traffic.
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            c = 4'($urandom_range(0, 14));
            if (c == 11 || c == 12) c = 15;
            exe_cmd = c;
            in_valid = 1'($urandom_range(0, 1));
            val1 = $urandom; val2 = (i % 3 == 0) ? W'($urandom_range(0, 40)) : $urandom;
            reg_2 = (i % 4 == 0) ? val1 : $urandom;
            pc = $urandom;
            br_type = 2'($urandom_range(0, 3));
            sel_a = SW'($urandom_range(0, 7)); sel_b = SW'($urandom_range(0, 7)); sel_st = SW'($urandom_range(0, 7));
            for (int k = 1; k <= NF; k++) src[k] = (i % 5 == 0) ? '0 : $urandom;
            #1;
            comb_check("rnd");
        end

        // Randomized multiply/divide operations.
        for (int i = 0; i < 4; i++)
            mdu_run(($urandom_range(0, 1) != 0) ? 4'd11 : 4'd12, $urandom,
                    (i == 0) ? W'($urandom_range(1, 300)) : $urandom, 1'($urandom_range(0, 1)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/exe_stage_mdu.md
# exe_stage_mdu

Parametrised execute stage for the five-stage MIPS pipeline: forwarded operand selection, single-cycle ALU, branch resolution, plus an iterative unsigned multiply/divide unit with HI/LO registers. Sits between the ID/EXE and EXE/MEM pipeline registers. While a multiply or divide runs, it stalls the upstream pipeline and issues bubbles downstream.

## Interface
- WIDTH, 32: datapath width; must be ≥ 4.
- FWD_SRCS, 2: number of forwarding sources. Source 1 is MEM, source 2 is WB, and later sources are extra pipeline taps.
- SEL_W, $clog2(FWD_SRCS+1): width of each forwarding select.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous assertion, active-low.
- in_valid  in  1  ID/EXE register holds a real instruction.
- exe_cmd  in  4  operation code.
- val1, val2, reg_2  in  WIDTH  operand A, operand B/immediate, store data.
- pc  in  WIDTH  PC+4 of the instruction.
- br_type  in  2  branch type: 0 none, 1 BEZ, 2 BNE, 3 JMP.
- sel_a, sel_b, sel_st  in  SEL_W  forwarding selects for A, B and store data.
- fwd_data  in  FWD_SRCS*WIDTH  forwarding values; source k occupies bits [k*WIDTH-1 -: WIDTH].
- alu_result  out  WIDTH  stage result.
- src2_val  out  WIDTH  forwarded store data.
- br_addr  out  WIDTH  branch target.
- br_taken  out  1  branch resolved taken.
- stall  out  1  hold the PC, IF/ID and ID/EXE registers.
- out_valid  out  1  result is valid for EXE/MEM; low means a bubble.

## Operation
- **Forwarding mux.** A select value of 0 selects the local operand. A value k in 1..FWD_SRCS selects fwd_data source k. A value above FWD_SRCS selects the local operand.
- **ALU commands.** exe_cmd 0–10 go to the existing ALU encoding, combinationally, using the forwarded A and B.
- **MDU commands.**
  - 11 MULU: {HI,LO} = A*B, full 2·WIDTH-bit product.
  - 12 DIVU: LO = A/B, HI = A%B.
  - 13 MFHI: alu_result = HI.
  - 14 MFLO: alu_result = LO.
  - 15: reserved; result 0.
- **Divide by zero.** LO = all ones and HI = dividend, which is the natural restoring-divide result. No trap is raised.
- **Multiplier.** Shift-add, one multiplier bit per cycle, over a 2·WIDTH accumulator.
- **Divider.** Restoring divide, one quotient bit per cycle.
- **MDU states.**
  - IDLE: a start is `in_valid && exe_cmd ∈ {11,12}`. On start, capture the forwarded A and B, load cnt = WIDTH-1, and go to BUSY. stall = 1 combinationally in the start cycle.
  - BUSY: do one iteration per cycle and hold stall = 1. On the cycle with cnt == 0, write HI/LO and go to DONE.
  - DONE: stall = 0. The held instruction retires with alu_result = LO (already updated). Starts are ignored in this state; go to IDLE next cycle.
- **out_valid** = in_valid && !stall.
- **Branches.** br_addr = pc + (val2 << 2), truncated to WIDTH, using the unforwarded val2.
- **Branch conditions.** br_taken uses the forwarded A and src2_val:
  - BEZ: A == 0.
  - BNE: A != src2_val.
  - JMP: always taken.
  - none: not taken.
  - br_taken is gated by in_valid.
- **Reset (rst low), at any time, including mid-operation.**
  - State goes to IDLE, cnt to 0, HI and LO to 0.
  - stall is 0 at once and any in-flight operation is discarded.
  - The combinational outputs follow the inputs, using HI = LO = 0.
- **MDU in flight.** Forwarding inputs and operand changes during BUSY have no effect on the captured operands.

## Timing
- ALU, MFHI/MFLO, branch and forwarding paths: zero-cycle latency, combinational through the stage.
- MULU/DIVU, with the start cycle as t0:
  - stall is high from t0 through t0+WIDTH, i.e. WIDTH+1 cycles.
  - HI/LO update at the t0+WIDTH clock edge.
  - The DONE cycle t0+WIDTH+1 has out_valid = 1.
- Back-to-back MDU operations: the second may start in the cycle after DONE. Its minimum issue interval is WIDTH+2.
- MFHI/MFLO in the cycle after DONE sees the new value; no interlock is needed.

## Structure
- Package exe_pkg holds:
  - CMD_MULU, CMD_DIVU, CMD_MFHI, CMD_MFLO.
  - BR_NONE, BR_BEZ, BR_BNE, BR_JMP.
  - The MDU state enum (IDLE/BUSY/DONE).
- Sub-module mdu_iter holds the state machine, counter, accumulator/remainder and HI/LO. Its interface is start, a, b, op, busy, done, hi, lo.
- The existing ALU and condition-check logic are reused, widened to WIDTH.

## Test plan
- **MULU 7×6, WIDTH=32:** stall high for 33 cycles, then DONE with out_valid = 1, HI = 0, LO = 42. An MFLO on the next cycle returns 42.
- **MULU 0xFFFFFFFF×0xFFFFFFFF:** HI = 0xFFFFFFFE, LO = 0x00000001.
- **DIVU 100/7:** LO = 14, HI = 2. **DIVU 5/0:** LO = 0xFFFFFFFF, HI = 5.
- **Reset mid-operation:** rst pulsed low at BUSY cycle 10 drives stall to 0 immediately and HI/LO to 0. A new MULU 3×3 then completes with LO = 9.
- **Forwarding, FWD_SRCS=3:** sel_a=3, fwd source 3 = 0x10, exe_cmd = ADD, val2 = 1 gives alu_result 0x11. sel_b=0 uses val2. sel_a=5 falls back to val1.
- **Branch:** BNE with forwarded A = 4 (sel_a = 1) and src2_val = 4 gives br_taken = 0. With pc = 0x100 and val2 = 3, br_addr = 0x10C. With in_valid = 0, br_taken = 0.
